// File: rtl/eth_measurer_pkg.sv
// Shared definitions for the Ethernet measurement transmitter/receiver pair.
// Contents: parser state enum, header length, broadcast MAC, and the fixed
// overhead subtracted from the length field to get the expected padding.
package eth_measurer_pkg;

  typedef enum logic [1:0] {
    ST_HEADER  = 2'd0,
    ST_PADDING = 2'd1,
    ST_DROP    = 2'd2
  } state_t;

  // dst(6) + src(6) + length(2) + identifier(4)
  localparam int          HDR_LEN      = 18;
  localparam int          HDR_BITS     = HDR_LEN * 8;
  localparam logic [47:0] BCAST_MAC    = 48'hFFFF_FFFF_FFFF;
  // The identifier word is counted by the length field but is not padding.
  localparam logic [15:0] LEN_OVERHEAD = 16'd4;

endpackage

// File: rtl/eth_measurer_rx.sv
// eth_measurer_rx: receive side of the Ethernet measurement link.
// Parses an 8-bit AXI-Stream frame, checks the broadcast destination, the
// peer source MAC, the length field and the identifier word, then counts the
// padding bytes that follow and reports whether they match the length field.
//
// Optional feature: define ETH_MEASURER_RX_TUSER_EN to add s_axis_tuser; a
// tuser=1 on the tlast beat marks the frame bad and forces rx_ok to 0.
//
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   s_axis_tdata   received byte, first byte of frame first
//   s_axis_tkeep   byte qualifier; tkeep=0 beats are accepted but not counted
//   s_axis_tlast   last beat of frame
//   s_axis_tvalid  beat valid
//   s_axis_tuser   MAC bad-frame flag on tlast (ETH_MEASURER_RX_TUSER_EN only)
//   s_axis_tready  0 in reset, constant 1 afterwards
//   rx_begin       combinational pulse on the first accepted beat of a frame
//   rx_done        registered pulse the cycle after a tlast beat is accepted
//   rx_ok          result of the last finished frame, held until next rx_done
//   rx_padding     padding bytes counted in the last finished frame
//
// Handshake: a beat transfers on any cycle where s_axis_tvalid and
// s_axis_tready are both 1; s_axis_tready never drops once out of reset.
module eth_measurer_rx
  import eth_measurer_pkg::*;
#(
  parameter logic [47:0] peer_mac   = 48'h0,
  parameter logic [31:0] identifier = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tvalid,
`ifdef ETH_MEASURER_RX_TUSER_EN
  input  logic        s_axis_tuser,
`endif
  output logic        s_axis_tready,
  output logic        rx_begin,
  output logic        rx_done,
  output logic        rx_ok,
  output logic [15:0] rx_padding
);

  localparam logic [15:0] HDR_LAST = 16'(HDR_LEN - 1);

  state_t              state_q, state_d;
  logic [15:0]         count_q, count_d;
  // Only the first 17 header bytes are stored; the 18th is checked straight
  // off the bus so a tlast on it can still be judged in the same cycle.
  logic [HDR_BITS-9:0] hdr_q, hdr_d;
  logic [15:0]         len_q, len_d;
  logic                in_frame_q, in_frame_d;
  logic                done_d, ok_d;
  logic [15:0]         pad_d;

  logic                beat_acc, beat_cnt, beat_last, frame_bad;
  logic [HDR_BITS-1:0] hdr_view;
  logic [15:0]         hdr_len, pad_cnt, end_pad;
  logic                hdr_pass, end_ok;

`ifdef ETH_MEASURER_RX_TUSER_EN
  assign frame_bad = s_axis_tuser;
`else
  assign frame_bad = 1'b0;
`endif

  assign beat_acc  = s_axis_tvalid && s_axis_tready;
  assign beat_cnt  = beat_acc && s_axis_tkeep;
  assign beat_last = beat_acc && s_axis_tlast;

  assign hdr_view = {hdr_q, s_axis_tdata};
  assign hdr_len  = hdr_view[47:32];
  assign hdr_pass = (hdr_view[143:96] == BCAST_MAC) &&
                    (hdr_view[95:48]  == peer_mac)  &&
                    (hdr_view[31:0]   == identifier) &&
                    (hdr_len >= LEN_OVERHEAD);

  // Padding count including the current beat, saturating at all-ones.
  assign pad_cnt = !beat_cnt           ? count_q :
                   (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

  // in_frame keeps tkeep=0 beats at the start of a frame from re-firing it.
  assign rx_begin = beat_acc && (state_q == ST_HEADER) &&
                    (count_q == 16'd0) && !in_frame_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    hdr_d      = hdr_q;
    len_d      = len_q;
    in_frame_d = in_frame_q;
    done_d     = 1'b0;
    ok_d       = rx_ok;
    pad_d      = rx_padding;
    end_ok     = 1'b0;
    end_pad    = 16'd0;

    case (state_q)
      ST_HEADER: begin
        // Only a zero-padding frame can finish successfully on header byte 18.
        end_ok = beat_cnt && (count_q == HDR_LAST) && hdr_pass &&
                 (hdr_len == LEN_OVERHEAD);
        if (beat_cnt) begin
          if (count_q == HDR_LAST) begin
            count_d = 16'd0;
            if (hdr_pass) begin
              state_d = ST_PADDING;
              len_d   = hdr_len;
            end else begin
              state_d = ST_DROP;
            end
          end else begin
            hdr_d   = hdr_view[HDR_BITS-9:0];
            count_d = count_q + 16'd1;
          end
        end
      end
      ST_PADDING: begin
        count_d = pad_cnt;
        end_pad = pad_cnt;
        end_ok  = (pad_cnt == (len_q - LEN_OVERHEAD));
      end
      ST_DROP: begin
      end
      default: state_d = ST_HEADER;
    endcase

    if (beat_acc) in_frame_d = 1'b1;

    if (beat_last) begin
      state_d    = ST_HEADER;
      count_d    = 16'd0;
      in_frame_d = 1'b0;
      done_d     = 1'b1;
      ok_d       = end_ok && !frame_bad;
      pad_d      = end_pad;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_HEADER;
      count_q       <= 16'd0;
      hdr_q         <= '0;
      len_q         <= 16'd0;
      in_frame_q    <= 1'b0;
      rx_done       <= 1'b0;
      rx_ok         <= 1'b0;
      rx_padding    <= 16'd0;
      s_axis_tready <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      hdr_q         <= hdr_d;
      len_q         <= len_d;
      in_frame_q    <= in_frame_d;
      rx_done       <= done_d;
      rx_ok         <= ok_d;
      rx_padding    <= pad_d;
      s_axis_tready <= 1'b1;
    end
  end

endmodule

// File: tb/tb_eth_measurer_rx.sv
// Directed bench for eth_measurer_rx: builds frames byte by byte, drives them
// over AXI-Stream and compares each rx_done result against an expected queue.
module tb_eth_measurer_rx;

  localparam logic [47:0] PEER = 48'h02_00_5E_10_20_30;
  localparam logic [31:0] ID   = 32'hCAFE_0001;

  logic        clk;
  logic        rst_n;
  logic [7:0]  tdata;
  logic        tkeep;
  logic        tlast;
  logic        tvalid;
  logic        tuser;
  logic        tready;
  logic        rx_begin;
  logic        rx_done;
  logic        rx_ok;
  logic [15:0] rx_padding;

  eth_measurer_rx #(
    .peer_mac   (PEER),
    .identifier (ID)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (tdata),
    .s_axis_tkeep  (tkeep),
    .s_axis_tlast  (tlast),
    .s_axis_tvalid (tvalid),
`ifdef ETH_MEASURER_RX_TUSER_EN
    .s_axis_tuser  (tuser),
`endif
    .s_axis_tready (tready),
    .rx_begin      (rx_begin),
    .rx_done       (rx_done),
    .rx_ok         (rx_ok),
    .rx_padding    (rx_padding)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int          n_checks;
  int          n_pass;
  int          begin_cnt;
  int          done_cnt;
  int          n_expected;
  logic [16:0] exp_q[$];   // {rx_ok, rx_padding}
  logic [16:0] mon_e;
  logic [7:0]  frm[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (rx_begin === 1'b1) begin_cnt++;
    if (rx_done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_rx_done", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rx_ok", {31'd0, rx_ok}, {31'd0, mon_e[16]});
        check("rx_padding", {16'd0, rx_padding}, {16'd0, mon_e[15:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic build(input logic [47:0] src, input logic [15:0] len,
                       input logic [31:0] id, input int npad);
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(8'hFF);
    for (int i = 5; i >= 0; i--) frm.push_back(src[i*8 +: 8]);
    frm.push_back(len[15:8]);
    frm.push_back(len[7:0]);
    for (int i = 3; i >= 0; i--) frm.push_back(id[i*8 +: 8]);
    for (int i = 0; i < npad; i++) frm.push_back(8'h20);
  endtask

  task automatic expect_frame(input logic ok, input logic [15:0] pad);
    exp_q.push_back({ok, pad});
    n_expected++;
  endtask

  // Sends the first nbeats bytes of frm; gap_at inserts a tkeep=0 beat
  // before that byte index (-1 for none).
  task automatic send(input int nbeats, input int gap_at, input bit last, input bit bad);
    for (int i = 0; i < nbeats; i++) begin
      if (i == gap_at) begin
        tvalid = 1'b1; tkeep = 1'b0; tdata = 8'h00; tlast = 1'b0; tuser = 1'b0;
        @(posedge clk); #1;
      end
      tvalid = 1'b1;
      tkeep  = 1'b1;
      tdata  = frm[i];
      tlast  = last && (i == nbeats - 1);
      tuser  = bad && last && (i == nbeats - 1);
      @(posedge clk); #1;
    end
    tvalid = 1'b0; tkeep = 1'b0; tlast = 1'b0; tuser = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(posedge clk);
      k++;
    end
    check({tag, "_drain"}, exp_q.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  int b0, d0;

  initial begin
    n_checks = 0; n_pass = 0; begin_cnt = 0; done_cnt = 0; n_expected = 0;
    rst_n = 1'b0; tvalid = 1'b0; tkeep = 1'b0; tlast = 1'b0; tuser = 1'b0; tdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tready", {31'd0, tready}, 32'd0);
    check("reset_rx_done", {31'd0, rx_done}, 32'd0);
    check("reset_rx_ok", {31'd0, rx_ok}, 32'd0);
    check("reset_rx_padding", {16'd0, rx_padding}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("tready_after_reset", {31'd0, tready}, 32'd1);

    // Valid frame, L=10, six padding bytes
    b0 = begin_cnt; d0 = done_cnt;
    build(PEER, 16'd10, ID, 6);
    expect_frame(1'b1, 16'd6);
    send(frm.size(), -1, 1'b1, 1'b0);
    drain("valid_l10");
    check("valid_l10_begins", begin_cnt - b0, 32'd1);
    check("valid_l10_dones", done_cnt - d0, 32'd1);

    // Identifier mismatch in the last identifier byte
    build(PEER, 16'd10, ID ^ 32'h0000_0001, 6);
    expect_frame(1'b0, 16'd0);
    send(frm.size(), -1, 1'b1, 1'b0);
    drain("id_mismatch");

    // Runt: tlast on the 10th byte
    build(PEER, 16'd10, ID, 6);
    expect_frame(1'b0, 16'd0);
    send(10, -1, 1'b1, 1'b0);
    drain("runt");

    // L=4 ending on header byte 18, then L=20 with 17 padding, no idle gap
    b0 = begin_cnt;
    build(PEER, 16'd4, ID, 0);
    expect_frame(1'b1, 16'd0);
    expect_frame(1'b0, 16'd17);
    send(frm.size(), -1, 1'b1, 1'b0);
    build(PEER, 16'd20, ID, 17);
    send(frm.size(), -1, 1'b1, 1'b0);
    drain("back_to_back");
    check("back_to_back_begins", begin_cnt - b0, 32'd2);

    // Reset at padding byte 3, then a full valid L=8 frame
    d0 = done_cnt;
    build(PEER, 16'd8, ID, 4);
    send(20, -1, 1'b0, 1'b0);
    tvalid = 1'b1; tkeep = 1'b1; tdata = 8'h20;
    rst_n = 1'b0;
    @(posedge clk); #1;
    tvalid = 1'b0; tkeep = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - d0, 32'd0);
    expect_frame(1'b1, 16'd4);
    send(frm.size(), -1, 1'b1, 1'b0);
    drain("after_reset_l8");

    // Leading tkeep=0 beat: one rx_begin, not counted as a byte
    b0 = begin_cnt;
    build(PEER, 16'd6, ID, 2);
    expect_frame(1'b1, 16'd2);
    send(frm.size(), 0, 1'b1, 1'b0);
    drain("keep_gap");
    check("keep_gap_begins", begin_cnt - b0, 32'd1);

    // Wrong source MAC
    build(PEER ^ 48'h1, 16'd10, ID, 6);
    expect_frame(1'b0, 16'd0);
    send(frm.size(), -1, 1'b1, 1'b0);
    drain("bad_src");

    // Length field below overhead, tlast on header byte 18
    build(PEER, 16'd3, ID, 0);
    expect_frame(1'b0, 16'd0);
    send(frm.size(), -1, 1'b1, 1'b0);
    drain("len_below_4");

    // Too few padding bytes
    build(PEER, 16'd10, ID, 3);
    expect_frame(1'b0, 16'd3);
    send(frm.size(), -1, 1'b1, 1'b0);
    drain("short_padding");

`ifdef ETH_MEASURER_RX_TUSER_EN
    // Bad-frame flag from the MAC on the tlast beat
    build(PEER, 16'd10, ID, 6);
    expect_frame(1'b0, 16'd6);
    send(frm.size(), -1, 1'b1, 1'b1);
    drain("tuser_bad");
`endif

    check("total_dones", done_cnt, n_expected);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
